// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - requester-side bundle for the shared interval counter scheduler
interface counter_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] req_len;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [CNT_W-1:0]       count;
    logic [N_REQ-1:0]       done;

    modport master (
        output req, req_len,
        input  gnt, busy, count, done
    );

    modport slave (
        input  req, req_len,
        output gnt, busy, count, done
    );
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one interval counter among requesters
module counter_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    counter_sched_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;

    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic [CNT_W-1:0]   win_len;
    logic               found;

    function automatic int wrap_idx(input int a);
        return (a >= N_REQ) ? a - N_REQ : a;
    endfunction

    // Search starts at ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        win     = '0;
        cand    = '0;
        found   = 1'b0;
        win_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'(wrap_idx(int'(ptr_q) + i));
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_len = bus.req_len[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        count_d = count_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d      = win;
                    len_d      = win_len;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    count_d    = '0;
                    ptr_d      = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
                    state_d    = RUN;
                end
            end
            RUN: begin
                // A dropped request wins over reaching the terminal count.
                if (!bus.req[idx_q]) begin
                    gnt_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (count_q == len_q) begin
                    done_d[idx_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one CNT_W-bit interval counter among N_REQ requesters. Each requester asks for a delay of `len` cycles. The block grants one requester at a time, runs the shared counter from 0 up to the latched length, then pulses that requester's done bit. It sits between the timer-consuming control blocks and the shared free-running counter datapath, replacing per-client counters with one sequenced instance.

## Interface
- `N_REQ`, default 4: number of requesters, minimum 2.
- `CNT_W`, default 8: counter and length width.
- `clk`  input  1: single clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  N_REQ: per-requester request level. Must be held until `done` for that requester.
- `req_len`  input  N_REQ*CNT_W: per-requester length. Slice i is bits [i*CNT_W +: CNT_W].
- `gnt`  output  N_REQ: one-hot grant, or all-zero.
- `busy`  output  1: high in RUN or DONE.
- `count`  output  CNT_W: shared counter value.
- `done`  output  N_REQ: one-hot, one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `gnt`=0, `done`=0, `busy`=0, `count`=0. Round-robin pointer `ptr`=0. Latched length=0, latched index=0.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (wrapping).
  - On that edge: latch the winner index and its `req_len` slice, set `gnt` one-hot for the winner, set `count`=0, go to RUN.
  - Set `ptr` = (winner+1) mod N_REQ.
  - If `req` is zero, stay in IDLE.
- **RUN:**
  - If `req[winner]`=0 (abort): clear `gnt` and `count` and go to IDLE. No `done` is issued.
  - Otherwise, if `count` == latched length: go to DONE with `count` held.
  - Otherwise: `count` <= `count` + 1.
- **DONE:**
  - `done[winner]`=1 and `gnt` still asserted for this one cycle.
  - Next edge: `done`=0, `gnt`=0, `count`=0, go to IDLE.
- Length 0 gives one RUN cycle (`count`=0), then DONE.
- Length 2^CNT_W-1 ends with `count` reaching all ones. `count` never wraps.
- `req_len` is sampled only at grant. Later changes have no effect on the current grant.
- Requests from non-granted requesters are ignored until the scheduler returns to IDLE. They are not lost as long as the requester holds `req`.
- `busy` = (state != IDLE).

## Timing
- All outputs are registered. No combinational path from input to output.
- Edge E0 is the IDLE edge where the request is seen:
  - After E0: `gnt` high and `count`=0.
  - `count` equals k after edge E0+k, for k ≤ len.
  - After edge E0+len+1: DONE, `done` high.
  - After edge E0+len+2: IDLE with all outputs zero.
- Grant-to-done latency: len+1 cycles. Total occupancy from grant to end of DONE: len+2 cycles.
- Back-to-back grants are separated by one IDLE cycle. Minimum period is len+3 cycles per request.
- Abort: `req[winner]` low on a RUN edge returns to IDLE after that edge. This takes priority over the `count`==len compare in the same cycle.
- `rst` asserted in any state forces reset values immediately (asynchronously). Operation resumes from IDLE with `ptr`=0 on the first edge after deassertion.

## Test plan
- **Single request:** `req`=0001, len0=3.
  - `gnt`=0001 with `count` 0,1,2,3 over four cycles.
  - `done`=0001 for one cycle at count 3.
  - IDLE with `count`=0 on the next cycle.
- **Round robin:** `req`=1111 held, all lengths 1.
  - Grant order 0,1,2,3,0.
  - Each grant lasts 3 cycles (2 RUN + 1 DONE), with one IDLE cycle between grants.
- **Length boundaries:**
  - len=0: `done` one cycle after the grant.
  - len=255 with CNT_W=8: `count` reaches 8'hFF, `done` asserts, and `count` never wraps to 0 while in RUN.
- **Abort:** grant requester 2 with len=10, drop `req[2]` at `count`=4.
  - Next cycle: `gnt`=0, `count`=0, no `done` pulse.
  - `ptr` is 3, so a waiting `req[3]` is granted next.
- **Reset mid-run:** pulse `rst` at `count`=5.
  - `gnt`, `count`, `busy` go to 0 without a clock edge.
  - After release with `req`=1010, requester 1 is granted first (`ptr`=0).
- **Length latching:** change `req_len` during RUN.
  - The original latched length still terminates the run.
  - The new value takes effect at the next grant.
